// File: rtl/byte_packer.sv
// Packs a valid-only byte stream into words behind a valid/ready output.
// Holds up to two words: the output register plus one full accumulator.
module byte_packer #(
  parameter int BYTES_PER_WORD = 4,
  parameter bit LSB_FIRST      = 1'b1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [7:0]                              din,
  input  logic                                    enable_in,
  input  logic                                    flush,
  output logic [8*BYTES_PER_WORD-1:0]             word_out,
  output logic [$clog2(BYTES_PER_WORD+1)-1:0]     word_bytes,
  output logic                                    word_valid,
  input  logic                                    word_ready,
  output logic                                    overflow,
  input  logic                                    clr_ovf
);

  localparam int W  = 8 * BYTES_PER_WORD;
  localparam int CW = $clog2(BYTES_PER_WORD + 1);

  typedef enum logic {FILLING, FULL} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    out_q, out_d;
  logic [CW-1:0]   bytes_q, bytes_d;
  logic            valid_q, valid_d;
  logic            ovf_q, ovf_d;

  logic            slot_free;
  logic [CW-1:0]   pos;
  logic [CW-1:0]   lane;
  logic [CW-1:0]   n;
  logic [W-1:0]    merged;
  logic            last;

  always_comb begin
    slot_free = !valid_q || word_ready;
    // In FULL an incoming byte can only start a fresh word.
    pos    = (state_q == FULL) ? '0 : cnt_q;
    lane   = LSB_FIRST ? pos : CW'(BYTES_PER_WORD - 1) - pos;
    merged = (state_q == FULL) ? '0 : acc_q;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (enable_in && lane == CW'(i)) merged[8*i +: 8] = din;
    end
    n    = pos + CW'(enable_in);
    last = enable_in && (pos == CW'(BYTES_PER_WORD - 1));

    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    bytes_d = bytes_q;
    valid_d = valid_q && !word_ready;
    ovf_d   = ovf_q && !clr_ovf;

    unique case (state_q)
      FILLING: begin
        if (last || (flush && n != '0)) begin
          if (slot_free) begin
            out_d   = merged;
            bytes_d = n;
            valid_d = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            state_d = FULL;
            acc_d   = merged;
            cnt_d   = n;
          end
        end else begin
          acc_d = merged;
          cnt_d = n;
        end
      end
      FULL: begin
        if (slot_free) begin
          out_d   = acc_q;
          bytes_d = cnt_q;
          valid_d = 1'b1;
          state_d = FILLING;
          acc_d   = merged;
          cnt_d   = n;
        end else if (enable_in) begin
          ovf_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILLING;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      bytes_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      bytes_q <= bytes_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign word_out   = out_q;
  assign word_bytes = bytes_q;
  assign word_valid = valid_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_byte_packer.sv
// Bench for byte_packer: LSB-first and MSB-first instances on shared stimulus.
// Cycle vectors for the simple cases, scoreboard queue for multi-word cases.
module tb_byte_packer;

  logic        clk = 1'b0;
  logic        rst_n, en, fl, rdy, clr;
  logic [7:0]  din;
  logic [31:0] wl, wm;
  logic [2:0]  bl, bm;
  logic        vl, vm, ol, om;
  logic        sb_on;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  byte_packer #(.BYTES_PER_WORD(4), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .din(din), .enable_in(en), .flush(fl),
    .word_out(wl), .word_bytes(bl), .word_valid(vl), .word_ready(rdy),
    .overflow(ol), .clr_ovf(clr)
  );

  byte_packer #(.BYTES_PER_WORD(4), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .din(din), .enable_in(en), .flush(fl),
    .word_out(wm), .word_bytes(bm), .word_valid(vm), .word_ready(rdy),
    .overflow(om), .clr_ovf(clr)
  );

  typedef struct packed {
    logic [31:0] w;
    logic [2:0]  b;
  } exp_t;

  exp_t q[$];

  typedef struct {
    logic        en;
    logic [7:0]  din;
    logic        fl;
    logic        exp_v;
    logic [31:0] exp_l;
    logic [31:0] exp_m;
    logic [2:0]  exp_b;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic cyc(input logic e, input logic [7:0] d, input logic f);
    en  = e;
    din = d;
    fl  = f;
    @(posedge clk);
    #1;
    en = 1'b0;
    fl = 1'b0;
  endtask

  task automatic push(input logic [31:0] w, input logic [2:0] b);
    exp_t x;
    x.w = w;
    x.b = b;
    q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (sb_on && vl && rdy) begin
      if (q.size() == 0) begin
        chk("sb_unexpected", wl, 32'hxxxx_xxxx);
      end else begin
        exp_t x;
        x = q.pop_front();
        chk("sb_word", wl, x.w);
        chk("sb_bytes", {29'd0, bl}, {29'd0, x.b});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0};
    tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0};
    tbl[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0};
    tbl[3]  = '{1'b1, 8'h44, 1'b0, 1'b1, 32'h44332211, 32'h11223344, 3'd4};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0};
    tbl[5]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0};
    tbl[6]  = '{1'b1, 8'hBB, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 32'h0000BBAA, 32'hAABB0000, 3'd2};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0, 3'd0};
    tbl[9]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0};
    tbl[10] = '{1'b1, 8'hBB, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0};
    tbl[11] = '{1'b1, 8'hCC, 1'b1, 1'b1, 32'h00CCBBAA, 32'hAABBCC00, 3'd3};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0};

    rst_n = 1'b0;
    en    = 1'b0;
    fl    = 1'b0;
    din   = 8'h00;
    rdy   = 1'b1;
    clr   = 1'b0;
    sb_on = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, vl}, 32'd0);
    chk("rst_word", wl, 32'd0);
    chk("rst_bytes", {29'd0, bl}, 32'd0);
    chk("rst_ovf", {31'd0, ol}, 32'd0);
    chk("rst_valid_m", {31'd0, vm}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].en, tbl[i].din, tbl[i].fl);
      chk($sformatf("vec%0d_valid", i), {31'd0, vl}, {31'd0, tbl[i].exp_v});
      chk($sformatf("vec%0d_valid_m", i), {31'd0, vm}, {31'd0, tbl[i].exp_v});
      if (tbl[i].exp_v) begin
        chk($sformatf("vec%0d_word", i), wl, tbl[i].exp_l);
        chk($sformatf("vec%0d_word_m", i), wm, tbl[i].exp_m);
        chk($sformatf("vec%0d_bytes", i), {29'd0, bl}, {29'd0, tbl[i].exp_b});
        chk($sformatf("vec%0d_bytes_m", i), {29'd0, bm}, {29'd0, tbl[i].exp_b});
      end
      chk($sformatf("vec%0d_ovf", i), {31'd0, ol}, 32'd0);
    end

    sb_on = 1'b1;
    rdy   = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b1, 8'(k), 1'b0);
      if (k == 4) push(32'h04030201, 3'd4);
      if (k == 8) push(32'h08070605, 3'd4);
    end
    chk("hold_valid", {31'd0, vl}, 32'd1);
    chk("hold_word", wl, 32'h04030201);
    chk("pre_drop_ovf", {31'd0, ol}, 32'd0);
    cyc(1'b1, 8'h09, 1'b0);
    chk("drop_ovf", {31'd0, ol}, 32'd1);
    chk("drop_hold_word", wl, 32'h04030201);
    rdy = 1'b1;
    repeat (3) cyc(1'b0, 8'h00, 1'b0);
    chk("drain_valid", {31'd0, vl}, 32'd0);
    chk("ovf_sticky", {31'd0, ol}, 32'd1);
    clr = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    clr = 1'b0;
    chk("ovf_clear", {31'd0, ol}, 32'd0);

    rdy = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 8'hA0 + 8'(k), 1'b0);
      if (k == 3) push(32'hA3A2A1A0, 3'd4);
      if (k == 7) push(32'hA7A6A5A4, 3'd4);
    end
    rdy = 1'b1;
    cyc(1'b1, 8'hB0, 1'b0);
    cyc(1'b1, 8'hB1, 1'b0);
    cyc(1'b1, 8'hB2, 1'b0);
    cyc(1'b1, 8'hB3, 1'b0);
    push(32'hB3B2B1B0, 3'd4);
    chk("same_edge_ovf", {31'd0, ol}, 32'd0);
    chk("same_edge_word", wl, 32'hB3B2B1B0);
    repeat (2) cyc(1'b0, 8'h00, 1'b0);

    cyc(1'b1, 8'h12, 1'b0);
    cyc(1'b1, 8'h34, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, vl}, 32'd0);
    chk("mid_rst_word", wl, 32'd0);
    chk("mid_rst_bytes", {29'd0, bl}, 32'd0);
    chk("mid_rst_ovf", {31'd0, ol}, 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b1, 8'h55, 1'b0);
    cyc(1'b1, 8'h66, 1'b0);
    cyc(1'b1, 8'h77, 1'b0);
    cyc(1'b1, 8'h88, 1'b0);
    push(32'h88776655, 3'd4);
    chk("post_rst_word", wl, 32'h88776655);
    repeat (3) cyc(1'b0, 8'h00, 1'b0);
    chk("sb_empty", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
